// File: rtl/pipeline_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush controller.
package pipeline_ctrl_pkg;

   localparam int unsigned REG_W            = 4;
   localparam int unsigned MAX_WAIT_DEFAULT = 255;
   localparam int unsigned CNT_W_DEFAULT    = 32;

   typedef enum logic [1:0] {
      ST_RUN      = 2'd0,
      ST_MEM_WAIT = 2'd1,
      ST_HALT     = 2'd2
   } state_e;

endpackage

// File: rtl/hazard_detector.sv
// Combinational load-use / RAW hazard detection for the instruction in ID.
module hazard_detector
   import pipeline_ctrl_pkg::*;
(
   input  logic             forward_en,
   input  logic [REG_W-1:0] id_src1,
   input  logic [REG_W-1:0] id_src2,
   input  logic             id_src1_valid,
   input  logic             id_two_src,
   input  logic [REG_W-1:0] exe_dest,
   input  logic             exe_wb_en,
   input  logic             exe_mem_read,
   input  logic [REG_W-1:0] mem_dest,
   input  logic             mem_wb_en,
   output logic             hazard_c
);

   logic exe_match;
   logic mem_match;

   assign exe_match = (id_src1_valid & (id_src1 == exe_dest)) |
                      (id_two_src    & (id_src2 == exe_dest));
   assign mem_match = (id_src1_valid & (id_src1 == mem_dest)) |
                      (id_two_src    & (id_src2 == mem_dest));

   // With forwarding only a load in EX still needs a bubble.
   assign hazard_c = forward_en ? (exe_wb_en & exe_mem_read & exe_match)
                                : ((exe_wb_en & exe_match) | (mem_wb_en & mem_match));

endmodule

// File: rtl/pipeline_controller.sv
// Stall/flush sequencer: hazard and branch resolution, memory-wait FSM with
// watchdog halt, and performance counters.
module pipeline_controller
   import pipeline_ctrl_pkg::*;
#(
   parameter int unsigned CNT_W    = CNT_W_DEFAULT,
   parameter int unsigned MAX_WAIT = MAX_WAIT_DEFAULT,
   parameter int unsigned WAIT_W   = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             forwardEn,
   input  logic [REG_W-1:0] idSrc1,
   input  logic [REG_W-1:0] idSrc2,
   input  logic             idSrc1Valid,
   input  logic             idTwoSrc,
   input  logic [REG_W-1:0] exeDest,
   input  logic             exeWbEn,
   input  logic             exeMemRead,
   input  logic [REG_W-1:0] memDest,
   input  logic             memWbEn,
   input  logic             branchTaken,
   input  logic             memReq,
   input  logic             memReady,
   input  logic             clrCounters,
   output logic             pcFreeze,
   output logic             ifIdFreeze,
   output logic             idExFreeze,
   output logic             exMemFreeze,
   output logic             ifIdFlush,
   output logic             idExFlush,
   output logic             memWbFlush,
   output logic             halted,
   output logic [CNT_W-1:0] cntCycle,
   output logic [CNT_W-1:0] cntBubble,
   output logic [CNT_W-1:0] cntFlush,
   output logic [CNT_W-1:0] cntMemWait
);

   state_e            state_q, state_d;
   logic [WAIT_W-1:0] wait_q, wait_d;
   logic [CNT_W-1:0]  cnt_cycle_q, cnt_cycle_d;
   logic [CNT_W-1:0]  cnt_bubble_q, cnt_bubble_d;
   logic [CNT_W-1:0]  cnt_flush_q, cnt_flush_d;
   logic [CNT_W-1:0]  cnt_mem_wait_q, cnt_mem_wait_d;

   logic hazard;
   logic mem_stall;
   logic is_stall;
   logic is_branch;
   logic is_bubble;

   hazard_detector u_hazard (
      .forward_en    (forwardEn),
      .id_src1       (idSrc1),
      .id_src2       (idSrc2),
      .id_src1_valid (idSrc1Valid),
      .id_two_src    (idTwoSrc),
      .exe_dest      (exeDest),
      .exe_wb_en     (exeWbEn),
      .exe_mem_read  (exeMemRead),
      .mem_dest      (memDest),
      .mem_wb_en     (memWbEn),
      .hazard_c      (hazard)
   );

   assign mem_stall = memReq & ~memReady;

   // Next state and prioritised pipeline controls; everything is quiet in reset.
   always_comb begin
      state_d     = state_q;
      wait_d      = wait_q;
      pcFreeze    = 1'b0;
      ifIdFreeze  = 1'b0;
      idExFreeze  = 1'b0;
      exMemFreeze = 1'b0;
      ifIdFlush   = 1'b0;
      idExFlush   = 1'b0;
      memWbFlush  = 1'b0;
      is_stall    = 1'b0;
      is_branch   = 1'b0;
      is_bubble   = 1'b0;
      if (!rst) begin
         if (state_q == ST_HALT) begin
            pcFreeze    = 1'b1;
            ifIdFreeze  = 1'b1;
            idExFreeze  = 1'b1;
            exMemFreeze = 1'b1;
         end else if (mem_stall) begin
            pcFreeze    = 1'b1;
            ifIdFreeze  = 1'b1;
            idExFreeze  = 1'b1;
            exMemFreeze = 1'b1;
            memWbFlush  = 1'b1;
            is_stall    = 1'b1;
            if (wait_q == WAIT_W'(MAX_WAIT)) begin
               state_d = ST_HALT;
            end else begin
               state_d = ST_MEM_WAIT;
               wait_d  = wait_q + WAIT_W'(1);
            end
         end else begin
            state_d = ST_RUN;
            wait_d  = '0;
            if (branchTaken) begin
               ifIdFlush = 1'b1;
               idExFlush = 1'b1;
               is_branch = 1'b1;
            end else if (hazard) begin
               pcFreeze   = 1'b1;
               ifIdFreeze = 1'b1;
               idExFlush  = 1'b1;
               is_bubble  = 1'b1;
            end
         end
      end
   end

   // Performance counters; clear wins over increment.
   always_comb begin
      cnt_cycle_d    = cnt_cycle_q;
      cnt_bubble_d   = cnt_bubble_q;
      cnt_flush_d    = cnt_flush_q;
      cnt_mem_wait_d = cnt_mem_wait_q;
      if (clrCounters) begin
         cnt_cycle_d    = '0;
         cnt_bubble_d   = '0;
         cnt_flush_d    = '0;
         cnt_mem_wait_d = '0;
      end else begin
         if (state_q != ST_HALT) cnt_cycle_d = cnt_cycle_q + CNT_W'(1);
         if (is_stall)  cnt_mem_wait_d = cnt_mem_wait_q + CNT_W'(1);
         if (is_branch) cnt_flush_d    = cnt_flush_q + CNT_W'(1);
         if (is_bubble) cnt_bubble_d   = cnt_bubble_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q        <= ST_RUN;
         wait_q         <= '0;
         cnt_cycle_q    <= '0;
         cnt_bubble_q   <= '0;
         cnt_flush_q    <= '0;
         cnt_mem_wait_q <= '0;
      end else begin
         state_q        <= state_d;
         wait_q         <= wait_d;
         cnt_cycle_q    <= cnt_cycle_d;
         cnt_bubble_q   <= cnt_bubble_d;
         cnt_flush_q    <= cnt_flush_d;
         cnt_mem_wait_q <= cnt_mem_wait_d;
      end
   end

   assign halted     = (state_q == ST_HALT);
   assign cntCycle   = cnt_cycle_q;
   assign cntBubble  = cnt_bubble_q;
   assign cntFlush   = cnt_flush_q;
   assign cntMemWait = cnt_mem_wait_q;

endmodule

// File: tb/tb_pipeline_controller.sv
// Self-checking bench for pipeline_controller: vector table plus multi-cycle
// sequences for memory wait, watchdog halt and counter clear.
module tb_pipeline_controller;

   logic        clk;
   logic        rst;
   logic        forwardEn;
   logic [3:0]  idSrc1, idSrc2, exeDest, memDest;
   logic        idSrc1Valid, idTwoSrc, exeWbEn, exeMemRead, memWbEn;
   logic        branchTaken, memReq, memReady, clrCounters;
   logic        pcFreeze, ifIdFreeze, idExFreeze, exMemFreeze;
   logic        ifIdFlush, idExFlush, memWbFlush, halted;
   logic [31:0] cntCycle, cntBubble, cntFlush, cntMemWait;
   logic [6:0]  ctrl;

   localparam logic [6:0] C_IDLE   = 7'b0000000;
   localparam logic [6:0] C_BUBBLE = 7'b1100010;
   localparam logic [6:0] C_BRANCH = 7'b0000110;
   localparam logic [6:0] C_STALL  = 7'b1111001;
   localparam logic [6:0] C_HALT   = 7'b1111000;

   pipeline_controller #(.CNT_W(32), .MAX_WAIT(4), .WAIT_W(8)) dut (
      .clk(clk), .rst(rst), .forwardEn(forwardEn),
      .idSrc1(idSrc1), .idSrc2(idSrc2), .idSrc1Valid(idSrc1Valid), .idTwoSrc(idTwoSrc),
      .exeDest(exeDest), .exeWbEn(exeWbEn), .exeMemRead(exeMemRead),
      .memDest(memDest), .memWbEn(memWbEn), .branchTaken(branchTaken),
      .memReq(memReq), .memReady(memReady), .clrCounters(clrCounters),
      .pcFreeze(pcFreeze), .ifIdFreeze(ifIdFreeze), .idExFreeze(idExFreeze),
      .exMemFreeze(exMemFreeze), .ifIdFlush(ifIdFlush), .idExFlush(idExFlush),
      .memWbFlush(memWbFlush), .halted(halted),
      .cntCycle(cntCycle), .cntBubble(cntBubble), .cntFlush(cntFlush), .cntMemWait(cntMemWait)
   );

   assign ctrl = {pcFreeze, ifIdFreeze, idExFreeze, exMemFreeze, ifIdFlush, idExFlush, memWbFlush};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic       fwd;
      logic [3:0] s1;
      logic       s1v;
      logic [3:0] s2;
      logic       two;
      logic [3:0] ed;
      logic       ewb;
      logic       emr;
      logic [3:0] md;
      logic       mwb;
      logic       br;
      logic       mreq;
      logic       mrdy;
   } in_t;

   typedef struct {
      in_t        in;
      logic [6:0] exp;
   } vec_t;

   typedef struct {
      int         id;
      logic [6:0] exp;
   } sb_t;

   vec_t vecs[12];
   sb_t  sb_q[$];
   int   n_cmp = 0;
   int   n_bad = 0;
   int   exp_cycle, exp_bubble, exp_flush, exp_mw;

   function automatic in_t mk(input logic fwd, input logic [3:0] s1, input logic s1v,
                              input logic [3:0] s2, input logic two, input logic [3:0] ed,
                              input logic ewb, input logic emr, input logic [3:0] md,
                              input logic mwb, input logic br, input logic mreq,
                              input logic mrdy);
      in_t r;
      r.fwd = fwd; r.s1 = s1; r.s1v = s1v; r.s2 = s2; r.two = two; r.ed = ed;
      r.ewb = ewb; r.emr = emr; r.md = md; r.mwb = mwb; r.br = br;
      r.mreq = mreq; r.mrdy = mrdy;
      return r;
   endfunction

   task automatic set_in(input in_t i);
      forwardEn = i.fwd; idSrc1 = i.s1; idSrc1Valid = i.s1v; idSrc2 = i.s2;
      idTwoSrc = i.two; exeDest = i.ed; exeWbEn = i.ewb; exeMemRead = i.emr;
      memDest = i.md; memWbEn = i.mwb; branchTaken = i.br;
      memReq = i.mreq; memReady = i.mrdy;
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic check_ctrl();
      sb_t s;
      if (sb_q.size() == 0) begin
         n_cmp++;
         n_bad++;
         $display("FAIL scoreboard_empty: got no entry, expected one");
      end else begin
         s = sb_q.pop_front();
         chk($sformatf("ctrl_%0d", s.id), {25'd0, ctrl}, {25'd0, s.exp});
      end
   endtask

   // Drive one cycle's inputs at the falling edge and check the controls before the rising edge.
   task automatic step(input in_t i, input logic [6:0] exp, input int id);
      sb_t s;
      @(negedge clk);
      set_in(i);
      s.id = id;
      s.exp = exp;
      sb_q.push_back(s);
      #1;
      check_ctrl();
   endtask

   task automatic clear_cycle(input int id);
      step(mk(0,0,0,0,0,0,0,0,0,0,0,0,0), C_IDLE, id);
      clrCounters = 1'b1;
      @(posedge clk);
      #1;
      clrCounters = 1'b0;
   endtask

   task automatic check_counters(input string tag, input int cyc, input int bub,
                                 input int fl, input int mw);
      chk({tag, "_cntCycle"},   cntCycle,   32'(cyc));
      chk({tag, "_cntBubble"},  cntBubble,  32'(bub));
      chk({tag, "_cntFlush"},   cntFlush,   32'(fl));
      chk({tag, "_cntMemWait"}, cntMemWait, 32'(mw));
   endtask

   in_t idle_in, lu_in, stall_br_in, rel_br_in, stall_in;

   initial begin
      idle_in     = mk(0,0,0,0,0,0,0,0,0,0,0,0,0);
      lu_in       = mk(1,3,1,0,0,3,1,1,0,0,0,0,0);
      stall_br_in = mk(0,0,0,0,0,0,0,0,0,0,1,1,0);
      rel_br_in   = mk(0,0,0,0,0,0,0,0,0,0,1,1,1);
      stall_in    = mk(0,0,0,0,0,0,0,0,0,0,0,1,0);

      vecs[0]  = '{mk(0,0,0,0,0,0,0,0,0,0,0,0,0), C_IDLE};
      vecs[1]  = '{mk(1,3,1,0,0,3,1,1,0,0,0,0,0), C_BUBBLE};
      vecs[2]  = '{mk(1,3,0,0,0,3,1,1,0,0,0,0,0), C_IDLE};
      vecs[3]  = '{mk(1,3,1,0,0,3,1,0,0,0,0,0,0), C_IDLE};
      vecs[4]  = '{mk(0,0,0,5,1,0,0,0,5,1,0,0,0), C_BUBBLE};
      vecs[5]  = '{mk(1,0,0,5,1,0,0,0,5,1,0,0,0), C_IDLE};
      vecs[6]  = '{mk(1,3,1,0,0,3,1,1,0,0,1,0,0), C_BRANCH};
      vecs[7]  = '{mk(0,0,0,7,0,7,1,0,0,0,0,0,0), C_IDLE};
      vecs[8]  = '{mk(0,0,0,2,1,2,1,0,0,0,0,0,0), C_BUBBLE};
      vecs[9]  = '{mk(0,0,0,0,0,0,0,0,0,0,1,1,1), C_BRANCH};
      vecs[10] = '{mk(0,0,0,0,0,0,0,0,0,0,1,1,0), C_STALL};
      vecs[11] = '{mk(0,9,1,0,0,9,0,1,0,0,0,0,0), C_IDLE};

      clrCounters = 1'b0;
      rst = 1'b0;
      set_in(lu_in);
      memReq = 1'b1;
      #1 rst = 1'b1;
      #2;
      chk("reset_ctrl", {25'd0, ctrl}, 32'd0);
      chk("reset_halted", {31'd0, halted}, 32'd0);
      check_counters("reset", 0, 0, 0, 0);

      @(negedge clk);
      set_in(idle_in);
      rst = 1'b0;

      // The idle edge right after reset release counts one cycle.
      exp_cycle = 1; exp_bubble = 0; exp_flush = 0; exp_mw = 0;
      for (int i = 0; i < 12; i++) begin
         step(vecs[i].in, vecs[i].exp, i);
         exp_cycle++;
         if (vecs[i].exp == C_BUBBLE) exp_bubble++;
         if (vecs[i].exp == C_BRANCH) exp_flush++;
         if (vecs[i].exp == C_STALL)  exp_mw++;
      end
      @(posedge clk);
      #1;
      check_counters("table", exp_cycle, exp_bubble, exp_flush, exp_mw);

      // Clear together with a hazard: the bubble is still issued but not counted.
      step(lu_in, C_BUBBLE, 100);
      clrCounters = 1'b1;
      @(posedge clk);
      #1;
      clrCounters = 1'b0;
      check_counters("clr", 0, 0, 0, 0);
      for (int i = 0; i < 10; i++) step(idle_in, C_IDLE, 101 + i);
      @(posedge clk);
      #1;
      check_counters("idle10", 10, 0, 0, 0);

      // Three-cycle memory wait with a branch frozen behind it.
      clear_cycle(200);
      for (int i = 0; i < 3; i++) step(stall_br_in, C_STALL, 201 + i);
      step(rel_br_in, C_BRANCH, 204);
      @(posedge clk);
      #1;
      check_counters("memwait", 4, 0, 1, 3);
      chk("memwait_halted", {31'd0, halted}, 32'd0);

      // Watchdog: five stall cycles, then sticky halt.
      clear_cycle(300);
      for (int i = 0; i < 5; i++) begin
         step(stall_in, C_STALL, 301 + i);
         chk($sformatf("wd_halted_%0d", i), {31'd0, halted}, 32'd0);
      end
      step(stall_in, C_HALT, 306);
      chk("wd_halted_set", {31'd0, halted}, 32'd1);
      for (int i = 0; i < 3; i++) begin
         step(rel_br_in, C_HALT, 307 + i);
         chk($sformatf("wd_halted_sticky_%0d", i), {31'd0, halted}, 32'd1);
      end
      @(posedge clk);
      #1;
      check_counters("halt", 5, 0, 0, 5);

      // Asynchronous reset mid-cycle must clear the halt without a clock edge.
      #2 rst = 1'b1;
      #1;
      chk("arst_halted", {31'd0, halted}, 32'd0);
      chk("arst_ctrl", {25'd0, ctrl}, 32'd0);
      check_counters("arst", 0, 0, 0, 0);
      @(negedge clk);
      rst = 1'b0;
      step(stall_in, C_STALL, 400);
      chk("post_rst_halted", {31'd0, halted}, 32'd0);
      step(idle_in, C_IDLE, 401);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
